// File: rtl/vadd_pkg.sv
// Shared constants and types for the vadd_arb block: lane geometry of the
// vector adder, the owner encoding and the shadow-pipe tag.
package vadd_pkg;

    localparam int LANES = 4;
    localparam int LW    = 8;
    localparam int LAT   = 2;
    localparam int VW    = LANES * LW;

    typedef logic [VW-1:0] lane_vec_t;

    typedef logic owner_t;

    localparam owner_t REQ0 = 1'b0;
    localparam owner_t REQ1 = 1'b1;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } pipe_tag_t;

    // The requester that is not the given one; used to break ties.
    function automatic owner_t other_owner(input owner_t o);
        return (o == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/vadd_arb_if.sv
// Bundle of all handshake and adder-side signals around vadd_arb.
// The slave modport is the arbiter's view; master is the parent/client view.
interface vadd_arb_if #(
    parameter int CW = 16
);
    import vadd_pkg::*;

    logic      req0_valid;
    logic      req0_ready;
    lane_vec_t req0_a;
    lane_vec_t req0_b;

    logic      req1_valid;
    logic      req1_ready;
    lane_vec_t req1_a;
    lane_vec_t req1_b;

    logic      rsp0_valid;
    logic      rsp0_ready;
    lane_vec_t rsp0_y;

    logic      rsp1_valid;
    logic      rsp1_ready;
    lane_vec_t rsp1_y;

    logic      vadd_en;
    lane_vec_t vadd_a;
    lane_vec_t vadd_b;
    lane_vec_t vadd_y;

    logic          busy;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp0_valid, rsp0_y,
        input  rsp0_ready,
        output rsp1_valid, rsp1_y,
        input  rsp1_ready,
        output vadd_en, vadd_a, vadd_b,
        input  vadd_y,
        output busy, cnt0, cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp0_valid, rsp0_y,
        output rsp0_ready,
        input  rsp1_valid, rsp1_y,
        output rsp1_ready,
        input  vadd_en, vadd_a, vadd_b,
        output vadd_y,
        input  busy, cnt0, cnt1
    );

endinterface

// File: rtl/vadd_rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// last time is chosen; the pointer only moves when a grant is actually taken.
module vadd_rr_arb2
    import vadd_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   valid0,
    input  logic   valid1,
    input  logic   advance,
    output owner_t winner,
    output logic   any_valid
);

    owner_t last;

    // Pick the winner from the current requests and the last-served pointer.
    always_comb begin
        winner    = REQ0;
        any_valid = valid0 || valid1;
        if (valid0 && valid1) begin
            winner = other_owner(last);
        end else if (valid1) begin
            winner = REQ1;
        end
    end

    // Remember who was served; starts at REQ1 so REQ0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last <= REQ1;
        end else if (advance && any_valid) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/vadd_arb.sv
// Shares one 2-stage SIMD vector adder between two requesters. Grants are
// round-robin, a shadow pipe tracks the owner of each in-flight op in step
// with the adder's registers, and a stalled response freezes the whole pipe.
module vadd_arb
    import vadd_pkg::*;
#(
    parameter int CW = 16
)
(
    input logic       clock,
    input logic       reset,
    vadd_arb_if.slave bus
);

    pipe_tag_t     pipe_q [LAT];
    pipe_tag_t     s2;
    pipe_tag_t     new_tag;
    owner_t        winner;
    logic          any_valid;
    logic          s2_ready;
    logic          en;
    logic          grant0;
    logic          grant1;
    logic          issue;
    logic          busy_w;
    lane_vec_t     op_a;
    lane_vec_t     op_b;
    logic [CW-1:0] cnt0_q;
    logic [CW-1:0] cnt1_q;

    vadd_rr_arb2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .valid0    (bus.req0_valid),
        .valid1    (bus.req1_valid),
        .advance   (en),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Global stall when the op at the adder output has an owner not ready to take it; grants qualified by it.
    always_comb begin
        s2       = pipe_q[LAT-1];
        s2_ready = (s2.owner == REQ1) ? bus.rsp1_ready : bus.rsp0_ready;
        en       = !(s2.valid && !s2_ready);
        grant0   = en && (winner == REQ0) && bus.req0_valid;
        grant1   = en && (winner == REQ1) && bus.req1_valid;
        issue    = grant0 || grant1;
        new_tag.valid = issue;
        new_tag.owner = grant1 ? REQ1 : REQ0;
    end

    // Steer the winner's operands to the adder; zeros when nobody is asking.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (any_valid) begin
            if (winner == REQ1) begin
                op_a = bus.req1_a;
                op_b = bus.req1_b;
            end else begin
                op_a = bus.req0_a;
                op_b = bus.req0_b;
            end
        end
    end

    // Shadow pipe advances only with the adder enable so tags stay aligned with vadd_y.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (en) begin
            pipe_q[0] <= new_tag;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Per-requester issue counters, free-running modulo 2^CW.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (grant0) begin
                cnt0_q <= cnt0_q + 1'b1;
            end
            if (grant1) begin
                cnt1_q <= cnt1_q + 1'b1;
            end
        end
    end

    // Busy while any stage of the shadow pipe holds a live op.
    always_comb begin
        busy_w = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy_w = busy_w | pipe_q[i].valid;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = s2.valid && (s2.owner == REQ0);
    assign bus.rsp1_valid = s2.valid && (s2.owner == REQ1);
    assign bus.rsp0_y     = bus.vadd_y;
    assign bus.rsp1_y     = bus.vadd_y;
    assign bus.vadd_en    = en;
    assign bus.vadd_a     = op_a;
    assign bus.vadd_b     = op_b;
    assign bus.busy       = busy_w;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;

endmodule
